// File: rtl/lspc_raster_timing_pkg.sv
// lspc_timing_pkg: default LSPC raster geometry, counter width and window compare helper.
package lspc_timing_pkg;
  localparam int CNT_W       = 9;
  localparam int H_TOTAL     = 384;
  localparam int V_TOTAL     = 264;
  localparam int H_SYNC_END  = 28;
  localparam int H_VIS_START = 56;
  localparam int H_VIS_END   = 376;
  localparam int V_SYNC_END  = 8;
  localparam int V_VIS_START = 16;
  localparam int V_VIS_END   = 240;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic nhsync;
    logic nvsync;
    logic nblank;
  } lvl_t;

  function automatic logic in_window(input cnt_t c, input cnt_t s, input cnt_t e);
    return (c >= s) && (c < e);
  endfunction
endpackage

// File: rtl/lspc_raster_timing_wrap_counter.sv
// lspc_wrap_counter: enable/wrap counter exposing its next value and a wrap-out strobe.
module lspc_wrap_counter
  import lspc_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output cnt_t o_cnt,
  output cnt_t o_nxt,
  output logic o_wrap
);
  cnt_t r_cnt;
  logic w_wrap;
  cnt_t w_nxt;

  // o_nxt lets the owner register decodes on the same edge the count moves
  always_comb begin
    w_wrap = i_en && (r_cnt == cnt_t'(TOTAL - 1));
    w_nxt  = w_wrap ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_nxt;

  assign o_cnt  = r_cnt;
  assign o_nxt  = w_nxt;
  assign o_wrap = w_wrap;
endmodule

// File: rtl/lspc_raster_timing.sv
// lspc_raster_timing: H/V raster counters with registered sync, blank, strobe and raster IRQ decodes.
module lspc_raster_timing
  import lspc_timing_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_V_TOTAL     = V_TOTAL,
  parameter int P_H_SYNC_END  = H_SYNC_END,
  parameter int P_H_VIS_START = H_VIS_START,
  parameter int P_H_VIS_END   = H_VIS_END,
  parameter int P_V_SYNC_END  = V_SYNC_END,
  parameter int P_V_VIS_START = V_VIS_START,
  parameter int P_V_VIS_END   = V_VIS_END
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             PCK_EN,
  input  logic [CNT_W-1:0] IRQ_LINE,
  input  logic             IRQ_EN,
  input  logic             IRQ_ACK,
  output logic [CNT_W-1:0] H_CNT,
  output logic [CNT_W-1:0] V_CNT,
  output logic             nHSYNC,
  output logic             nVSYNC,
  output logic             nBLANK,
  output logic             LINE_START,
  output logic             FRAME_START,
  output logic             nIRQ_RASTER
);
  cnt_t w_h_nxt, w_v_nxt;
  logic w_h_wrap, w_v_wrap;
  logic w_irq_set;
  lvl_t w_lvl, r_lvl;
  logic r_ls, r_fs, r_nirq;

  lspc_wrap_counter #(.TOTAL(P_H_TOTAL)) u_h (
    .i_clk  (CLK),
    .i_rst_n(nRESET),
    .i_en   (PCK_EN),
    .o_cnt  (H_CNT),
    .o_nxt  (w_h_nxt),
    .o_wrap (w_h_wrap)
  );

  lspc_wrap_counter #(.TOTAL(P_V_TOTAL)) u_v (
    .i_clk  (CLK),
    .i_rst_n(nRESET),
    .i_en   (w_h_wrap),
    .o_cnt  (V_CNT),
    .o_nxt  (w_v_nxt),
    .o_wrap (w_v_wrap)
  );

  // Next counts equal current counts when PCK_EN is low, so levels hold for free
  always_comb begin
    w_lvl.nhsync = !in_window(w_h_nxt, '0, cnt_t'(P_H_SYNC_END));
    w_lvl.nvsync = !in_window(w_v_nxt, '0, cnt_t'(P_V_SYNC_END));
    w_lvl.nblank = in_window(w_h_nxt, cnt_t'(P_H_VIS_START), cnt_t'(P_H_VIS_END)) &&
                   in_window(w_v_nxt, cnt_t'(P_V_VIS_START), cnt_t'(P_V_VIS_END));
    w_irq_set    = w_h_wrap && IRQ_EN && (w_v_nxt == IRQ_LINE);
  end

  // V wraps only on an H wrap, so its wrap-out marks both counters returning to 0
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      r_lvl  <= '0;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
      r_nirq <= 1'b1;
    end else begin
      r_lvl  <= w_lvl;
      r_ls   <= w_h_wrap;
      r_fs   <= w_v_wrap;
      r_nirq <= w_irq_set ? 1'b0 : IRQ_ACK ? 1'b1 : r_nirq;
    end

  assign nHSYNC      = r_lvl.nhsync;
  assign nVSYNC      = r_lvl.nvsync;
  assign nBLANK      = r_lvl.nblank;
  assign LINE_START  = r_ls;
  assign FRAME_START = r_fs;
  assign nIRQ_RASTER = r_nirq;
endmodule

// File: tb/tb_lspc_raster_timing.sv
// tb_lspc_raster_timing: vector table, corner sequences and random run against an enable-count model.
module tb_lspc_raster_timing;
  localparam int BHT = 384, BVT = 264, BHSE = 28, BHVS = 56, BHVE = 376, BVSE = 8, BVVS = 16, BVVE = 240;
  localparam int SHT = 24, SVT = 12, SHSE = 3, SHVS = 5, SHVE = 21, SVSE = 2, SVVS = 3, SVVE = 10;

  logic       CLK = 1'b0;
  logic       nRESET, PCK_EN, IRQ_EN, IRQ_ACK;
  logic [8:0] IRQ_LINE;
  logic [8:0] b_h, b_v, s_h, s_v;
  logic       b_hs, b_vs, b_bl, b_ls, b_fs, b_irq;
  logic       s_hs, s_vs, s_bl, s_ls, s_fs, s_irq;

  always #5 CLK = ~CLK;

  lspc_raster_timing u_big (
    .CLK(CLK), .nRESET(nRESET), .PCK_EN(PCK_EN), .IRQ_LINE(IRQ_LINE), .IRQ_EN(IRQ_EN), .IRQ_ACK(IRQ_ACK),
    .H_CNT(b_h), .V_CNT(b_v), .nHSYNC(b_hs), .nVSYNC(b_vs), .nBLANK(b_bl),
    .LINE_START(b_ls), .FRAME_START(b_fs), .nIRQ_RASTER(b_irq)
  );

  lspc_raster_timing #(
    .P_H_TOTAL(SHT), .P_V_TOTAL(SVT), .P_H_SYNC_END(SHSE), .P_H_VIS_START(SHVS), .P_H_VIS_END(SHVE),
    .P_V_SYNC_END(SVSE), .P_V_VIS_START(SVVS), .P_V_VIS_END(SVVE)
  ) u_small (
    .CLK(CLK), .nRESET(nRESET), .PCK_EN(PCK_EN), .IRQ_LINE(IRQ_LINE), .IRQ_EN(IRQ_EN), .IRQ_ACK(IRQ_ACK),
    .H_CNT(s_h), .V_CNT(s_v), .nHSYNC(s_hs), .nVSYNC(s_vs), .nBLANK(s_bl),
    .LINE_START(s_ls), .FRAME_START(s_fs), .nIRQ_RASTER(s_irq)
  );

  typedef struct {
    int steps;
    int gap;
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int n = 0;
  bit ls_b, fs_b, pb, ls_s, fs_s, ps;
  bit mon_a = 0, mon_d = 0;
  int c_ls = 0, c_hs = 0, c_fs = 0, c_bl = 0, c_irq = 0;
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position is just the enable count since reset, split by division
  task automatic chk_dut(input string p, input logic [8:0] h, v, input logic hs, vs, bl, ls, fs, irq,
                         input int ht, vt, hse, hvs, hve, vse, vvs, vve, input bit els, efs, ep);
    int eh, ev;
    eh = n % ht;
    ev = (n / ht) % vt;
    chk({p, ".h_cnt"}, int'(h), eh);
    chk({p, ".v_cnt"}, int'(v), ev);
    chk({p, ".nhsync"}, int'(hs), int'(eh >= hse));
    chk({p, ".nvsync"}, int'(vs), int'(ev >= vse));
    chk({p, ".nblank"}, int'(bl), int'(eh >= hvs && eh < hve && ev >= vvs && ev < vve));
    chk({p, ".line_start"}, int'(ls), int'(els));
    chk({p, ".frame_start"}, int'(fs), int'(efs));
    chk({p, ".nirq"}, int'(irq), int'(!ep));
  endtask

  task automatic check_all();
    chk_dut("big", b_h, b_v, b_hs, b_vs, b_bl, b_ls, b_fs, b_irq,
            BHT, BVT, BHSE, BHVS, BHVE, BVSE, BVVS, BVVE, ls_b, fs_b, pb);
    chk_dut("small", s_h, s_v, s_hs, s_vs, s_bl, s_ls, s_fs, s_irq,
            SHT, SVT, SHSE, SHVS, SHVE, SVSE, SVVS, SVVE, ls_s, fs_s, ps);
  endtask

  task automatic cyc(input bit en);
    PCK_EN = en;
    @(posedge CLK);
    if (nRESET) begin
      int nn;
      nn = n + int'(en);
      ls_b = en && nn % BHT == 0;
      fs_b = en && nn % (BHT * BVT) == 0;
      pb   = (en && IRQ_EN && nn % BHT == 0 && int'(IRQ_LINE) == (nn / BHT) % BVT) ? 1'b1 : IRQ_ACK ? 1'b0 : pb;
      ls_s = en && nn % SHT == 0;
      fs_s = en && nn % (SHT * SVT) == 0;
      ps   = (en && IRQ_EN && nn % SHT == 0 && int'(IRQ_LINE) == (nn / SHT) % SVT) ? 1'b1 : IRQ_ACK ? 1'b0 : ps;
      n    = nn;
    end
    #1;
    check_all();
    if (mon_a) begin
      if (b_ls) c_ls++;
      if (en && !b_hs) c_hs++;
      if (s_fs) c_fs++;
      if (en && s_bl && n <= SHT * SVT) c_bl++;
    end
    if (mon_d && !s_irq) c_irq++;
  endtask

  task automatic run(input int steps, input int gap);
    repeat (steps) begin
      repeat (gap - 1) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    n = 0;
    {ls_b, fs_b, pb, ls_s, fs_s, ps} = '0;
    #1;
    chk("rst.h_cnt", int'(b_h), 0);
    chk("rst.v_cnt", int'(b_v), 0);
    chk("rst.nhsync", int'(b_hs), 0);
    chk("rst.nvsync", int'(b_vs), 0);
    chk("rst.nblank", int'(b_bl), 0);
    chk("rst.line_start", int'(b_ls), 0);
    chk("rst.frame_start", int'(b_fs), 0);
    chk("rst.nirq", int'(b_irq), 1);
    check_all();
    cyc(1'b0);
    cyc(1'b1);
    nRESET = 1'b1;
  endtask

  initial begin
    nRESET = 1'b0;
    PCK_EN = 1'b0;
    IRQ_EN = 1'b0;
    IRQ_ACK = 1'b0;
    IRQ_LINE = '0;
    tbl[0]  = '{1,    4, 1,   0,  0, 0, 0};
    tbl[1]  = '{26,   4, 27,  0,  0, 0, 0};
    tbl[2]  = '{1,    4, 28,  0,  1, 0, 0};
    tbl[3]  = '{28,   4, 56,  0,  1, 0, 0};
    tbl[4]  = '{232,  4, 288, 0,  1, 0, 0};
    tbl[5]  = '{95,   4, 383, 0,  1, 0, 0};
    tbl[6]  = '{1,    4, 0,   1,  0, 0, 0};
    tbl[7]  = '{2687, 1, 383, 7,  1, 0, 0};
    tbl[8]  = '{1,    1, 0,   8,  0, 1, 0};
    tbl[9]  = '{3128, 1, 56,  16, 1, 1, 1};
    tbl[10] = '{1,    1, 57,  16, 1, 1, 1};
    tbl[11] = '{319,  1, 376, 16, 1, 1, 0};
    repeat (3) cyc(1'b0);
    nRESET = 1'b1;
    mon_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) mon_a = 1'b0;
      run(tbl[i].steps, tbl[i].gap);
      chk("tbl.h_cnt", int'(b_h), tbl[i].h);
      chk("tbl.v_cnt", int'(b_v), tbl[i].v);
      chk("tbl.nhsync", int'(b_hs), int'(tbl[i].hs));
      chk("tbl.nvsync", int'(b_vs), int'(tbl[i].vs));
      chk("tbl.nblank", int'(b_bl), int'(tbl[i].bl));
    end
    chk("line1.line_start_count", c_ls, 1);
    chk("line1.hsync_low_enables", c_hs, 28);
    chk("sframe.frame_start_count", c_fs, 1);
    chk("sframe.blank_high_enables", c_bl, 112);
    // set and ack on the same line-start edge
    IRQ_LINE = 9'd49;
    IRQ_EN = 1'b1;
    run(12295, 1);
    chk("irq49.pre", int'(b_irq), 1);
    IRQ_ACK = 1'b1;
    cyc(1'b1);
    chk("irq49.set_wins", int'(b_irq), 0);
    chk("irq49.line_start", int'(b_ls), 1);
    chk("irq49.v_cnt", int'(b_v), 49);
    cyc(1'b0);
    chk("irq49.ack_release", int'(b_irq), 1);
    IRQ_ACK = 1'b0;
    IRQ_LINE = 9'd50;
    run(383, 1);
    chk("irq50.pre", int'(b_irq), 1);
    cyc(1'b1);
    chk("irq50.fire", int'(b_irq), 0);
    chk("irq50.line_start", int'(b_ls), 1);
    chk("irq50.v_cnt", int'(b_v), 50);
    IRQ_EN = 1'b0;
    run(200, 1);
    chk("irq50.h_cnt", int'(b_h), 200);
    chk("irq50.pending", int'(b_irq), 0);
    do_reset();
    cyc(1'b1);
    chk("post_rst.h_cnt", int'(b_h), 1);
    chk("post_rst.line_start", int'(b_ls), 0);
    chk("post_rst.nirq", int'(b_irq), 1);
    IRQ_LINE = 9'd3;
    IRQ_EN = 1'b1;
    run(71, 1);
    chk("s_irq3.fire", int'(s_irq), 0);
    chk("s_irq3.line_start", int'(s_ls), 1);
    chk("s_irq3.v_cnt", int'(s_v), 3);
    IRQ_EN = 1'b0;
    run(288, 1);
    chk("s_irq3.held_en_off", int'(s_irq), 0);
    IRQ_ACK = 1'b1;
    cyc(1'b0);
    chk("s_irq3.ack", int'(s_irq), 1);
    IRQ_ACK = 1'b0;
    IRQ_EN = 1'b1;
    run(287, 1);
    chk("s_irq3.no_refire", int'(s_irq), 1);
    cyc(1'b1);
    chk("s_irq3.next_frame", int'(s_irq), 0);
    chk("s_irq3.v_cnt2", int'(s_v), 3);
    IRQ_ACK = 1'b1;
    cyc(1'b0);
    IRQ_ACK = 1'b0;
    IRQ_LINE = 9'd12;
    mon_d = 1'b1;
    run(2 * SHT * SVT, 1);
    mon_d = 1'b0;
    chk("s_irq_out_of_range.low_cycles", c_irq, 0);
    for (int i = 0; i < 3000; i++) begin
      IRQ_LINE = 9'($urandom_range(0, 15));
      IRQ_EN = 1'($urandom % 2);
      IRQ_ACK = ($urandom % 6 == 0);
      if (i == 1500) do_reset();
      cyc($urandom % 3 != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
